seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised, iterative shift-add multiplier for the ALU: WIDTH-bit operands, 2*WIDTH-bit product, selectable signed/unsigned mode per operation, and an overflow flag meaning "product does not fit in WIDTH bits". Operands are captured on a valid/ready handshake. One partial-product step runs per clock, and the result is held until the consumer accepts it. It supersedes the single-shot combinational multiplier so that wide multiplies no longer sit in one combinational path.

## Interface
- WIDTH, 64, operand width in bits (≥2); product is 2*WIDTH.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- prod  output  2*WIDTH  product, registered.
- ovf  output  1  product not representable in WIDTH bits of the selected mode.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE: in_ready=1. On in_valid, the block captures the operands.
  - Signed mode: magnitudes |a| and |b| (two's-complement negate when MSB=1), and neg = a[W-1]^b[W-1].
  - Unsigned mode: raw values, and neg=0.
  - Accumulator {hi=0, lo=|b|}; step counter=0; go to CALC.
- CALC, one step per cycle:
  - If lo[0]=1, hi = hi + |a|. The carry-out is kept as the shift-in bit.
  - Then {carry,hi,lo} >>= 1 and counter++.
  - After step WIDTH-1, go to SIGN.
- SIGN:
  - prod = neg ? (~acc + 1) : acc.
  - ovf computation:
    - Signed mode: ovf = (prod[2W-1:W] != {W{prod[W-1]}}).
    - Unsigned mode: ovf = (prod[2W-1:W] != 0).
  - out_valid is set; go to DONE.
- DONE: prod, ovf and out_valid are held stable. On out_ready, out_valid is cleared and the block goes to IDLE.
- The most-negative operand (-2^(W-1)) has magnitude 2^(W-1), which fits in W unsigned bits. No special case.
- a, b and is_signed are ignored outside the accept cycle.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, prod=0, ovf=0, counter=0.
- rst overrides everything, including mid-CALC and DONE. An in-flight operation is discarded with no output.
- Accept edge = T (in_valid & in_ready).
  - CALC edges T+1..T+WIDTH.
  - SIGN edge T+WIDTH+1.
  - out_valid is high after edge T+WIDTH+1, which gives a latency of WIDTH+2 clocks (no early termination).
- No back-to-back overlap.
  - in_ready returns the cycle after the out_valid&out_ready edge.
  - in_valid during that handshake cycle is not accepted.
- out_ready low holds DONE indefinitely.
- out_ready high before out_valid has no effect.

## Configuration
- MULT_EARLY_TERM_EN defined:
  - In CALC, if the unprocessed multiplier bits above the current step are all zero, the remaining right-shift is applied in one step and the block goes to SIGN.
  - If k is the index of the highest set bit of |b|, CALC takes k+1 cycles, or 1 cycle when |b|=0.
  - Latency is k+3 clocks.
- Undefined: CALC is always exactly WIDTH cycles.
- Results (prod, ovf) are identical in both builds; only latency differs.

## Test plan
- WIDTH=8, signed, a=0xFD (-3), b=0x05 -> prod=0xFFF1, ovf=0. out_valid at accept+10 clocks without the macro.
- WIDTH=8, signed, a=0x80, b=0x80 -> prod=0x4000, ovf=1. Signed, a=0x80, b=0x01 -> prod=0xFF80, ovf=0.
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> prod=0xFE01, ovf=1. Unsigned, a=0x0F, b=0x11 -> prod=0x00FF, ovf=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> prod/ovf stable and in_ready=0 throughout. Pulse out_ready -> out_valid=0 next cycle, in_ready=1.
- Assert rst at CALC step 3 -> next cycle IDLE, in_ready=1, out_valid=0, prod=0. A new request then completes correctly.
- With MULT_EARLY_TERM_EN: b=0x01 -> out_valid at accept+3. b=0x00 -> prod=0 at accept+3. b=0x80 unsigned -> accept+10. Results match the build without the macro.

Source files
------------

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Iterative shift-add multiplier. It has WIDTH-bit operands and a
// 2*WIDTH-bit product. Signed or unsigned mode is chosen per operation.
// The block handles one partial-product step per clock. Signed operands
// are multiplied as magnitudes, and the sign is applied once at the end.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request
//   in_ready   high only while idle
//   a, b       multiplicand / multiplier (WIDTH bits)
//   is_signed  1 = two's-complement operands, sampled with a/b
//   out_valid  result available, held until out_ready
//   out_ready  consumer accepts the result
//   prod       registered 2*WIDTH-bit product
//   ovf        product does not fit in WIDTH bits of the selected mode
//
// Optional feature: define MULT_EARLY_TERM_EN to stop the iteration once
// the remaining multiplier bits are all zero. Results are identical; only
// the latency shrinks.
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             neg;
    logic             sgn_mode;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    acc_next;
    logic             last_step;
    logic [PW-1:0]    prod_next;
    logic             ovf_next;

`ifdef MULT_EARLY_TERM_EN
    // Multiplier bits not yet consumed; bit 0 is the bit used by the current step.
    logic [WIDTH-1:0] mrem;
    logic             early_done;
    logic [CW-1:0]    shamt;
`endif

    // Datapath: operand magnitudes, one add-and-shift step, final sign fix-up
    always_comb begin
        a_mag_in  = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag_in  = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

        // Carry-out of the add becomes the bit shifted into hi
        sum       = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
        acc_step  = {sum, lo[WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
        // Once no set multiplier bits remain above this step, every later
        // step would only shift, so all of those shifts are done now.
        early_done = ((mrem >> 1) == '0);
        shamt      = CW'(WIDTH - 1) - cnt;
        acc_next   = early_done ? (acc_step >> shamt) : acc_step;
        last_step  = (cnt == CW'(WIDTH - 1)) || early_done;
`else
        acc_next   = acc_step;
        last_step  = (cnt == CW'(WIDTH - 1));
`endif

        acc       = {hi, lo};
        prod_next = neg ? (~acc + PW'(1)) : acc;
        if (sgn_mode) begin
            ovf_next = (prod_next[PW-1:WIDTH] != {WIDTH{prod_next[WIDTH-1]}});
        end else begin
            ovf_next = (prod_next[PW-1:WIDTH] != '0);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = CALC;
            CALC: if (last_step) state_next = SIGN;
            SIGN:                state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture, iteration registers and the result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag    <= '0;
            hi       <= '0;
            lo       <= '0;
            neg      <= 1'b0;
            sgn_mode <= 1'b0;
            cnt      <= '0;
            prod     <= '0;
            ovf      <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
            mrem     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_mag    <= a_mag_in;
                        hi       <= '0;
                        lo       <= b_mag_in;
                        neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_mode <= is_signed;
                        cnt      <= '0;
`ifdef MULT_EARLY_TERM_EN
                        mrem     <= b_mag_in;
`endif
                    end
                end
                CALC: begin
                    hi  <= acc_next[PW-1:WIDTH];
                    lo  <= acc_next[WIDTH-1:0];
                    cnt <= cnt + CW'(1);
`ifdef MULT_EARLY_TERM_EN
                    mrem <= mrem >> 1;
`endif
                end
                SIGN: begin
                    prod <= prod_next;
                    ovf  <= ovf_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed bench for seq_multiplier at WIDTH=8. A reference model computes
// the expected product, overflow and latency for each request. These
// expectations are queued when a request is driven and are compared when
// out_valid appears. Covers reset state, signed and unsigned corner cases,
// backpressure, out_ready asserted early, reset in the middle of CALC, and a
// request presented during the output handshake.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        logic           ovf;
        int             lat;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] prod;
    logic           ovf;

    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: full-precision multiply plus range check
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sv);
        exp_t   e;
        longint p;
        if (sv) p = longint'($signed(av)) * longint'($signed(bv));
        else    p = longint'(av) * longint'(bv);
        e.prod = p[2*W-1:0];
        e.ovf  = sv ? ((p > 127) || (p < -128)) : (p > 255);
`ifdef MULT_EARLY_TERM_EN
        begin
            logic [W-1:0] bm;
            int           k;
            bm = (sv && bv[W-1]) ? (~bv + 8'd1) : bv;
            k  = 0;
            for (int i = 0; i < W; i++) if (bm[i]) k = i;
            e.lat = k + 3;
        end
`else
        e.lat = W + 2;
`endif
        return e;
    endfunction

    // Present one request; returns just after the accept edge
    task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic sv);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_output("in_ready_before_accept", in_ready, 1'b1);
        a         = av;
        b         = bv;
        is_signed = sv;
        in_valid  = 1'b1;
        sb.push_back(model(av, bv, sv));
        tick();
        in_valid  = 1'b0;
        a         = 8'hA5;
        b         = 8'h5A;
        is_signed = ~sv;
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall,
    // then complete the handshake
    task automatic wait_result(input int hold, input bit early_ready, input bit probe);
        exp_t e;
        int   cycles;
        out_ready = early_ready;
        cycles    = 1;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        e = sb.pop_front();
        check_output("out_valid", out_valid, 1'b1);
        check_output("latency", 64'(cycles), 64'(e.lat));
        check_output("prod", prod, e.prod);
        check_output("ovf", ovf, e.ovf);
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                check_output("hold_prod", prod, e.prod);
                check_output("hold_ovf", ovf, e.ovf);
                check_output("hold_out_valid", out_valid, 1'b1);
                check_output("hold_in_ready", in_ready, 1'b0);
            end
        end
        out_ready = 1'b1;
        if (probe) begin
            in_valid = 1'b1;
            a        = 8'h33;
            b        = 8'h44;
        end
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_output("post_hs_out_valid", out_valid, 1'b0);
        check_output("post_hs_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        is_signed    = 1'b0;
        out_ready    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        check_output("rst_in_ready", in_ready, 1'b1);
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_prod", prod, 16'h0000);
        check_output("rst_ovf", ovf, 1'b0);

        $display("[TB] signed cases");
        apply_stimulus(8'hFD, 8'h05, 1'b1);
        wait_result(0, 1'b0, 1'b0);
        apply_stimulus(8'h80, 8'h80, 1'b1);
        wait_result(0, 1'b0, 1'b0);
        apply_stimulus(8'h80, 8'h01, 1'b1);
        wait_result(0, 1'b0, 1'b0);
        apply_stimulus(8'h7F, 8'hFF, 1'b1);
        wait_result(0, 1'b0, 1'b0);

        $display("[TB] unsigned cases with backpressure and early out_ready");
        apply_stimulus(8'hFF, 8'hFF, 1'b0);
        wait_result(20, 1'b0, 1'b0);
        apply_stimulus(8'h0F, 8'h11, 1'b0);
        wait_result(0, 1'b1, 1'b0);

        $display("[TB] reset during CALC");
        apply_stimulus(8'hC3, 8'h9B, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        check_output("midrst_in_ready", in_ready, 1'b1);
        check_output("midrst_out_valid", out_valid, 1'b0);
        check_output("midrst_prod", prod, 16'h0000);
        check_output("midrst_ovf", ovf, 1'b0);
        apply_stimulus(8'h03, 8'h07, 1'b0);
        wait_result(0, 1'b0, 1'b0);

        $display("[TB] multiplier-length corners");
        apply_stimulus(8'h5A, 8'h01, 1'b0);
        wait_result(0, 1'b0, 1'b0);
        apply_stimulus(8'h5A, 8'h00, 1'b0);
        wait_result(0, 1'b0, 1'b0);
        apply_stimulus(8'h02, 8'h80, 1'b0);
        wait_result(0, 1'b0, 1'b0);
        apply_stimulus(8'hB7, 8'h0C, 1'b1);
        wait_result(0, 1'b0, 1'b1);

        // A request presented during the handshake cycle must not be taken
        tick();
        check_output("probe_in_ready", in_ready, 1'b1);
        check_output("probe_out_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
